alu_control_seq: RTL
====================

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 SHALL have parameter CW, default 5, ALUControl width; legal values >= 4.
REQ-002 SHALL have parameter MUL_LAT, default 4, mult/multu stall cycles; legal values >= 2.
REQ-003 SHALL have parameter DIV_LAT, default 32, div/divu stall cycles; legal values >= 2.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1, current instruction valid.
REQ-007 SHALL have port ALUOp, input, 2, main-decoder ALU class.
REQ-008 SHALL have port Funct, input, 6, R-type funct field.
REQ-009 SHALL have port ALUControl, output, CW, ALU operation code.
REQ-010 SHALL have port illegal, output, 1, unknown R-type funct.
REQ-011 SHALL have port stall, output, 1, hold PC/register writes.
REQ-012 SHALL have port md_start, output, 1, one-cycle mult/div launch pulse.
REQ-013 SHALL have port md_signed, output, 1, registered: latched op is signed.
REQ-014 SHALL have port md_div, output, 1, registered: latched op is divide.
REQ-015 SHALL have port hilo_we, output, 1, one-cycle HI/LO write enable.
REQ-016 SHALL have port md_busy, output, 1, sequencer not IDLE.

Function
REQ-017 SHALL drive ALUControl combinationally, zero-extended to CW. Codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, XOR=5, NOR=6, SLL=7, SRL=8, SRA=9, MULT=10, MULTU=11, DIV=12, DIVU=13, SLTU=14.
REQ-018 SHALL decode ALUOp 00->ADD, 01->SUB, 11->OR, independent of Funct.
REQ-019 SHALL decode ALUOp 10 by Funct:
- 20/21->ADD; 22/23->SUB; 24->AND; 25->OR; 26->XOR; 27->NOR.
- 2A->SLT; 2B->SLTU; 00->SLL; 02->SRL; 03->SRA.
- 18->MULT; 19->MULTU; 1A->DIV; 1B->DIVU.
REQ-020 SHALL, for ALUOp 10 with any other Funct, output ADD and assert illegal; illegal = valid_in & ALUOp==10 & unknown funct, combinational.
REQ-021 SHALL define issue = valid_in & ALUOp==10 & Funct in {18,19,1A,1B} & state==IDLE.
REQ-022 SHALL implement FSM IDLE, RUN, DONE with a down-counter sized for max(MUL_LAT, DIV_LAT).
REQ-023 SHALL, on issue at cycle T:
- pulse md_start at T (combinational);
- latch md_signed (18/1A) and md_div (1A/1B);
- load LAT-1 into counter, LAT = MUL_LAT or DIV_LAT;
- enter RUN at T+1.
REQ-024 SHALL, in RUN, decrement the counter each cycle and enter DONE on the cycle after the counter reaches 1, so RUN occupies T+1..T+LAT-1.
REQ-025 SHALL, in DONE (cycle T+LAT), assert hilo_we for exactly one cycle and return to IDLE at T+LAT+1.
REQ-026 SHALL drive stall = issue | (state==RUN), giving exactly LAT stall cycles T..T+LAT-1; stall is low in DONE.
REQ-027 SHALL NOT re-issue in RUN or DONE while the same mult/div instruction is still presented.
REQ-028 SHALL allow a new issue in the cycle directly after DONE (back-to-back mult/div).
REQ-029 SHALL ignore valid_in=0 for issue but still decode ALUControl.
REQ-030 SHALL keep ALUControl reflecting the current inputs during stall; the sequencer never alters it.
REQ-031 SHALL drive md_busy = state!=IDLE.

Reset
REQ-032 SHALL, on rst high (any cycle, including mid-RUN), immediately force state=IDLE, counter=0, md_signed=0, md_div=0, so that stall=0 (absent issue), hilo_we=0, md_busy=0.
REQ-033 SHALL suppress issue and md_start while rst is high; the first issue is allowed on the first rising edge after rst falls.

Verification
REQ-034 SHALL cover: ALUOp=10, Funct=2A -> ALUControl=4, illegal=0, stall=0; Funct=3F -> ALUControl=0, illegal=1.
REQ-035 SHALL cover: MULT (Funct=18) held, MUL_LAT=4 -> md_start at T; stall high T..T+3; hilo_we only at T+4; md_signed=1, md_div=0; no second md_start.
REQ-036 SHALL cover: DIVU (1B), DIV_LAT=32 -> stall high 32 cycles; hilo_we at T+32; md_signed=0, md_div=1.
REQ-037 SHALL cover: MULTU at T+5 right after a MULT issued at T (MUL_LAT=4) -> second md_start at T+5; stall high T+5..T+8.
REQ-038 SHALL cover: rst pulse at T+10 of a DIV -> stall, md_busy, hilo_we drop immediately; no hilo_we afterward; a new issue is accepted after release.
REQ-039 SHALL cover: MULT presented with valid_in=0 -> no md_start, stall=0, ALUControl=10.

Source files
------------

// File: rtl/alu_control_seq.sv
// ALU control decoder with a mult/div stall sequencer.
// Ports: clk, rst (async high), valid_in, ALUOp, Funct in;
//        ALUControl, illegal, stall, md_start, md_signed, md_div,
//        hilo_we, md_busy out.
module alu_control_seq #(
    parameter int CW      = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [1:0]    ALUOp,
    input  logic [5:0]    Funct,
    output logic [CW-1:0] ALUControl,
    output logic          illegal,
    output logic          stall,
    output logic          md_start,
    output logic          md_signed,
    output logic          md_div,
    output logic          hilo_we,
    output logic          md_busy
);

    localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNTW   = (MAXLAT > 2) ? $clog2(MAXLAT) : 1;

    localparam logic [CNTW-1:0] MUL_LOAD = CNTW'(MUL_LAT - 1);
    localparam logic [CNTW-1:0] DIV_LOAD = CNTW'(DIV_LAT - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    localparam logic [CW-1:0] C_ADD   = CW'(0);
    localparam logic [CW-1:0] C_SUB   = CW'(1);
    localparam logic [CW-1:0] C_AND   = CW'(2);
    localparam logic [CW-1:0] C_OR    = CW'(3);
    localparam logic [CW-1:0] C_SLT   = CW'(4);
    localparam logic [CW-1:0] C_XOR   = CW'(5);
    localparam logic [CW-1:0] C_NOR   = CW'(6);
    localparam logic [CW-1:0] C_SLL   = CW'(7);
    localparam logic [CW-1:0] C_SRL   = CW'(8);
    localparam logic [CW-1:0] C_SRA   = CW'(9);
    localparam logic [CW-1:0] C_MULT  = CW'(10);
    localparam logic [CW-1:0] C_MULTU = CW'(11);
    localparam logic [CW-1:0] C_DIV   = CW'(12);
    localparam logic [CW-1:0] C_DIVU  = CW'(13);
    localparam logic [CW-1:0] C_SLTU  = CW'(14);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic            unknown;
    logic            is_md;
    logic            issue;

    // Operation decode; purely combinational, never touched by the sequencer.
    always_comb begin
        ALUControl = C_ADD;
        unknown    = 1'b0;
        is_md      = 1'b0;
        unique case (ALUOp)
            2'b00: ALUControl = C_ADD;
            2'b01: ALUControl = C_SUB;
            2'b11: ALUControl = C_OR;
            2'b10: begin
                case (Funct)
                    6'h20, 6'h21: ALUControl = C_ADD;
                    6'h22, 6'h23: ALUControl = C_SUB;
                    6'h24: ALUControl = C_AND;
                    6'h25: ALUControl = C_OR;
                    6'h26: ALUControl = C_XOR;
                    6'h27: ALUControl = C_NOR;
                    6'h2A: ALUControl = C_SLT;
                    6'h2B: ALUControl = C_SLTU;
                    6'h00: ALUControl = C_SLL;
                    6'h02: ALUControl = C_SRL;
                    6'h03: ALUControl = C_SRA;
                    6'h18: begin ALUControl = C_MULT;  is_md = 1'b1; end
                    6'h19: begin ALUControl = C_MULTU; is_md = 1'b1; end
                    6'h1A: begin ALUControl = C_DIV;   is_md = 1'b1; end
                    6'h1B: begin ALUControl = C_DIVU;  is_md = 1'b1; end
                    default: begin
                        ALUControl = C_ADD;
                        unknown    = 1'b1;
                    end
                endcase
            end
            default: ALUControl = C_ADD;
        endcase
    end

    assign illegal  = valid_in & (ALUOp == 2'b10) & unknown;

    // rst gates issue so nothing launches while reset is held.
    assign issue    = valid_in & is_md & (state == IDLE) & ~rst;
    assign md_start = issue;
    assign stall    = issue | (state == RUN);

    // Funct[0] set = unsigned variant, Funct[1] set = divide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            md_signed <= 1'b0;
            md_div    <= 1'b0;
            hilo_we   <= 1'b0;
            md_busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    hilo_we <= 1'b0;
                    if (issue) begin
                        state     <= RUN;
                        md_busy   <= 1'b1;
                        md_signed <= ~Funct[0];
                        md_div    <= Funct[1];
                        cnt       <= Funct[1] ? DIV_LOAD : MUL_LOAD;
                    end
                end
                RUN: begin
                    if (cnt <= CNT_ONE) begin
                        state   <= DONE;
                        hilo_we <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    hilo_we <= 1'b0;
                    md_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    hilo_we <= 1'b0;
                    md_busy <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule
